pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised elastic pipeline register chain: DEPTH stages of WIDTH-bit registers with per-stage valid bits and valid/ready handshakes on both sides. It generalises the single enable-gated pipeline register to multi-stage depth with backpressure, bubble collapsing, synchronous flush and an occupancy count. It sits between pipeline phases of the microcontroller datapath, for example fetch to decode and decode to execute, wherever a stall or branch flush must propagate cleanly.

## Interface
- WIDTH, 8, data bits per stage.
- DEPTH, 3, number of register stages; legal range is DEPTH ≥ 1.
- ZERO_INVALID, 1: 1 forces out_data to 0 while out_valid=0; 0 presents the last-stage register unconditionally.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; reset=0 clears state immediately, independent of clk.
- in_valid  input  1  upstream beat present.
- in_data  input  WIDTH  upstream beat.
- in_ready  output  1  chain accepts a beat this cycle (combinational).
- out_valid  output  1  last stage holds a beat (registered).
- out_data  output  WIDTH  last-stage data, gated by ZERO_INVALID.
- out_ready  input  1  downstream consumes the beat this cycle.
- flush  input  1  synchronous discard of all held beats.
- count  output  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Stages s0..s(DEPTH-1). s0 is fed by the input; s(DEPTH-1) drives the outputs. Each stage holds v[k] and d[k].
- Advance enable: adv[DEPTH-1] = ~v[DEPTH-1] | out_ready; for k < DEPTH-1, adv[k] = ~v[k] | adv[k+1]. adv is a combinational backward ripple.
- in_ready = adv[0] & ~flush.
- A transfer occurs on input when in_valid & in_ready, and on output when out_valid & out_ready.
- On each edge with flush=0, every stage with adv[k]=1 loads from its predecessor. s0 takes (in_valid, in_data); stage k takes (v[k-1], d[k-1]).
- d[k] is written only when the incoming valid is 1. Otherwise d[k] holds, and only v[k] clears.
- Stages with adv[k]=0 hold both v and d. This is a stall.
- Bubbles collapse: an empty stage accepts a beat even while a later stage stalls.
- Flush (flush=1 at an edge) clears all v[k] to 0, and d is unchanged.
  - in_ready=0 during flush, so no input beat is lost silently.
  - A downstream transfer in the flush cycle (out_valid & out_ready) still counts as delivered.
- count is the combinational popcount of v[0..DEPTH-1], with no added latency.
- out_data is 0 when ZERO_INVALID=1 and v[DEPTH-1]=0; otherwise it is d[DEPTH-1].
- Ordering: beats leave in acceptance order. There is no duplication and no loss except by flush.

## Timing
- Reset (reset=0): all v=0 and all d=0, so out_valid=0, out_data=0 and count=0. in_ready follows its equation (=1 unless flush=1).
- Reset release is seen at the first rising edge after reset goes high.
- Reset asserted mid-operation drops all beats asynchronously. out_valid falls with no clock needed.
- Latency: a beat accepted at edge N on an empty, non-stalled chain shows out_valid=1 after edge N+DEPTH-1. That is, it enters s0 at edge N and reaches s(DEPTH-1) DEPTH-1 edges later.
- Throughput: one beat per cycle when out_ready=1 continuously.
- Full chain (count=DEPTH) with out_ready=0: in_ready=0 and all registers hold. With out_ready=1 on a full chain, in_ready=1 in the same cycle (pass-through ripple), so there is no bubble.
- Empty chain: out_valid=0. out_ready is a don't-care and causes no state change.
- Simultaneous flush and in_valid: the input is not accepted and the chain is empty after the edge.
- Simultaneous flush and out transfer: the beat is delivered and the chain is empty after the edge.
- DEPTH=1 degenerates to a single registered handshake stage with the same rules.

## Test plan
- Reset and fill: hold reset=0, then release. Drive in_data=0x11,0x22,0x33 with in_valid=1 and out_ready=1. Required: out_valid rises after edge DEPTH-1 following the first acceptance, then out_data=0x11,0x22,0x33 on consecutive cycles, with count ≤ 3 throughout.
- Backpressure fill: out_ready=0, stream 0xA0..0xA4. Required: in_ready drops after 3 acceptances and count=3. Then set out_ready=1: outputs are 0xA0,0xA1,0xA2 in order, then 0xA3,0xA4, with no loss or duplication.
- Bubble collapse: accept 0x01, idle one cycle, accept 0x02, with out_ready=0. Required: both beats pack into s2 and s1, count=2 and in_ready=1.
- Flush: with chain full (0x5A,0x5B,0x5C) and out_ready=1, pulse flush for one cycle with in_valid=1 and in_data=0x77. Required: 0x5C is delivered that cycle and in_ready=0. Next cycle out_valid=0, count=0, out_data=0, and 0x77 is never output.
- Async reset mid-stream: assert reset=0 between edges with count=2. Required: out_valid=0, count=0 and out_data=0 before the next edge.
- ZERO_INVALID=0, DEPTH=1: send 0x3C, then drain. Required: out_data stays 0x3C after out_valid falls, and single-stage latency is 0 edges beyond acceptance.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for the elastic pipeline chain: upstream beat, downstream beat,
// flush request and occupancy.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage elastic register chain with valid/ready on both sides, bubble
// collapsing, synchronous flush and a combinational occupancy count.
module pipe_stage_chain #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 3,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_stage_chain_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_din [DEPTH];
  logic [CW-1:0]    w_count;

  // A stage may advance when some stage at or after it is empty, or the sink
  // drains; computed as a running "tail is full" product to avoid a bitwise loop.
  always_comb begin : adv_ripple
    logic l_tail_full;
    l_tail_full = 1'b1;
    w_adv       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      l_tail_full = l_tail_full & r_v[k];
      w_adv[k]    = ~l_tail_full | bus.out_ready;
    end
  end

  always_comb begin
    w_vin[0] = bus.in_valid;
    w_din[0] = bus.in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_vin[k] = r_v[k-1];
      w_din[k] = r_d[k-1];
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CW'(r_v[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else if (bus.flush) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_vin[k];
          // Data only moves with a real beat so an emptied stage keeps its last value.
          if (w_vin[k]) begin
            r_d[k] <= w_din[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_adv[0] & ~bus.flush;
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = (ZERO_INVALID && !r_v[DEPTH-1]) ? '0 : r_d[DEPTH-1];
  assign bus.count     = w_count;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: expected beats go into per-DUT queues at issue time and
// negedge monitors pop and compare on every downstream transfer.
module tb_pipe_stage_chain;
  logic clk;
  logic reset;

  pipe_stage_chain_if #(.WIDTH(8), .DEPTH(3)) b0 ();
  pipe_stage_chain_if #(.WIDTH(8), .DEPTH(1)) b1 ();

  pipe_stage_chain #(.WIDTH(8), .DEPTH(3), .ZERO_INVALID(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  pipe_stage_chain #(.WIDTH(8), .DEPTH(1), .ZERO_INVALID(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL mon0_unexpected got=%0h expected=none at %0t", b0.out_data, $time);
      end else begin
        chk("mon0_data", b0.out_data, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL mon1_unexpected got=%0h expected=none at %0t", b1.out_data, $time);
      end else begin
        chk("mon1_data", b1.out_data, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    b0.in_valid = 0; b0.in_data = 0; b0.out_ready = 0; b0.flush = 0;
    b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 0; b1.flush = 0;
    #3;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_count", b0.count, 0);
    chk("rst_out_data", b0.out_data, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_d1_out_data", b1.out_data, 0);
    #5 reset = 1'b1;
    step();

    // Fill at full throughput: latency DEPTH-1 edges after acceptance
    b0.out_ready = 1; b0.in_valid = 1; b0.in_data = 8'h11;
    q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h33);
    step();
    chk("fill_ov_e0", b0.out_valid, 0);
    chk("fill_cnt_e0", b0.count, 1);
    b0.in_data = 8'h22;
    step();
    chk("fill_ov_e1", b0.out_valid, 0);
    b0.in_data = 8'h33;
    step();
    chk("fill_ov_e2", b0.out_valid, 1);
    chk("fill_data_e2", b0.out_data, 8'h11);
    chk("fill_cnt_e2", b0.count, 3);
    b0.in_valid = 0;
    repeat (3) step();
    chk("fill_cnt_end", b0.count, 0);
    chk("fill_q_empty", q0.size(), 0);

    // Backpressure: three accepted, then stall, then release with pass-through
    b0.out_ready = 0; b0.in_valid = 1;
    for (int i = 0; i < 5; i++) q0.push_back(8'hA0 + 8'(i));
    b0.in_data = 8'hA0; step();
    b0.in_data = 8'hA1; step();
    b0.in_data = 8'hA2; step();
    chk("bp_cnt_full", b0.count, 3);
    chk("bp_in_ready_full", b0.in_ready, 0);
    b0.in_data = 8'hA3; step();
    chk("bp_cnt_hold", b0.count, 3);
    chk("bp_data_hold", b0.out_data, 8'hA0);
    b0.out_ready = 1;
    #1;
    chk("bp_passthru_ready", b0.in_ready, 1);
    step();
    b0.in_data = 8'hA4; step();
    b0.in_valid = 0;
    repeat (3) step();
    chk("bp_cnt_end", b0.count, 0);
    chk("bp_q_empty", q0.size(), 0);

    // Bubble collapse under stall
    b0.out_ready = 0;
    q0.push_back(8'h01); q0.push_back(8'h02);
    b0.in_valid = 1; b0.in_data = 8'h01; step();
    b0.in_valid = 0; step();
    b0.in_valid = 1; b0.in_data = 8'h02; step();
    b0.in_valid = 0; step();
    chk("bub_cnt", b0.count, 2);
    chk("bub_in_ready", b0.in_ready, 1);
    chk("bub_out_data", b0.out_data, 8'h01);
    b0.out_ready = 1;
    repeat (2) step();
    chk("bub_cnt_end", b0.count, 0);

    // Flush with a concurrent delivery and a rejected input
    b0.out_ready = 0; b0.in_valid = 1;
    q0.push_back(8'h5C);
    b0.in_data = 8'h5C; step();
    b0.in_data = 8'h5B; step();
    b0.in_data = 8'h5A; step();
    chk("fl_cnt_full", b0.count, 3);
    b0.out_ready = 1; b0.flush = 1; b0.in_data = 8'h77;
    #1;
    chk("fl_in_ready", b0.in_ready, 0);
    step();
    b0.flush = 0; b0.in_valid = 0;
    chk("fl_out_valid", b0.out_valid, 0);
    chk("fl_cnt", b0.count, 0);
    chk("fl_out_data", b0.out_data, 0);
    repeat (3) step();
    chk("fl_q_empty", q0.size(), 0);

    // Asynchronous reset between edges
    b0.out_ready = 0; b0.in_valid = 1;
    b0.in_data = 8'hE1; step();
    b0.in_data = 8'hE2; step();
    b0.in_valid = 0;
    chk("ar_cnt_pre", b0.count, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", b0.out_valid, 0);
    chk("ar_cnt", b0.count, 0);
    chk("ar_out_data", b0.out_data, 0);
    #1 reset = 1'b1;
    step();

    // Single stage, data presented even when invalid
    b1.out_ready = 0; b1.in_valid = 1; b1.in_data = 8'h3C;
    q1.push_back(8'h3C);
    step();
    b1.in_valid = 0;
    chk("d1_out_valid", b1.out_valid, 1);
    chk("d1_out_data", b1.out_data, 8'h3C);
    chk("d1_cnt", b1.count, 1);
    chk("d1_in_ready_full", b1.in_ready, 0);
    b1.out_ready = 1;
    #1;
    chk("d1_in_ready_pass", b1.in_ready, 1);
    step();
    chk("d1_out_valid_end", b1.out_valid, 0);
    chk("d1_out_data_kept", b1.out_data, 8'h3C);
    chk("d1_q_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
